// File: rtl/score_pulse_gen.sv
// Score pulse generator: accumulates scoring events in a saturating pending
// counter and drains them as evenly spaced single-point pulses on des.
module score_pulse_gen #(
    parameter int PULSE_CYCLES = 4,
    parameter int GAP_CYCLES   = 4,
    parameter int PEND_W       = 4
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              hit_valid,
    input  logic [2:0]        hit_points,
    input  logic              clear,
    output logic              des,
    output logic [PEND_W-1:0] pending,
    output logic              busy,
    output logic              overflow
);

    localparam int MAX_CYCLES = (PULSE_CYCLES > GAP_CYCLES) ? PULSE_CYCLES : GAP_CYCLES;
    localparam int CNT_W      = (MAX_CYCLES > 1) ? $clog2(MAX_CYCLES) : 1;
    localparam logic [CNT_W-1:0] PULSE_LOAD = CNT_W'(PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LOAD   = CNT_W'(GAP_CYCLES - 1);
    localparam logic [PEND_W:0]  PEND_MAX   = {1'b0, {PEND_W{1'b1}}};

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HIGH = 2'd1,
        ST_LOW  = 2'd2
    } state_t;

    state_t             state, state_next;
    logic [CNT_W-1:0]   cnt, cnt_next;
    logic               dec;
    logic [PEND_W:0]    add_ext;
    logic [PEND_W:0]    sum;
    logic [PEND_W-1:0]  pending_next;
    logic               overflow_next;

    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        dec        = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!clear && pending != '0) begin
                    state_next = ST_HIGH;
                    cnt_next   = PULSE_LOAD;
                    dec        = 1'b1;
                end
            end
            ST_HIGH: begin
                // A clear cuts the pulse short but still honours a full gap.
                if (clear || cnt == '0) begin
                    state_next = ST_LOW;
                    cnt_next   = GAP_LOAD;
                end else begin
                    cnt_next = cnt - CNT_W'(1);
                end
            end
            ST_LOW: begin
                if (cnt != '0) begin
                    cnt_next = cnt - CNT_W'(1);
                end else if (!clear && pending != '0) begin
                    state_next = ST_HIGH;
                    cnt_next   = PULSE_LOAD;
                    dec        = 1'b1;
                end else begin
                    state_next = ST_IDLE;
                end
            end
            default: begin
                state_next = ST_IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    // One extra bit of headroom detects saturation; dec only fires with pending != 0.
    always_comb begin
        add_ext       = hit_valid ? {{(PEND_W-2){1'b0}}, hit_points} : '0;
        sum           = {1'b0, pending} + add_ext - {{PEND_W{1'b0}}, dec};
        pending_next  = sum[PEND_W-1:0];
        overflow_next = overflow;
        if (clear) begin
            pending_next  = '0;
            overflow_next = 1'b0;
        end else if (sum > PEND_MAX) begin
            pending_next  = PEND_MAX[PEND_W-1:0];
            overflow_next = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state    <= ST_IDLE;
            cnt      <= '0;
            des      <= 1'b0;
            pending  <= '0;
            overflow <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            des      <= (state_next == ST_HIGH);
            pending  <= pending_next;
            overflow <= overflow_next;
        end
    end

    assign busy = (state != ST_IDLE) || (pending != '0);

endmodule

// File: doc/score_pulse_gen.md
# score_pulse_gen

Converts scoring events from the game logic into a stream of clean, evenly spaced single-point pulses on `des`. The edge-triggered decimal score display counts one per `des` rising edge, and this block drives it. Multi-point events and back-to-back hits are accumulated in a saturating pending counter. That counter is then drained one point per pulse, with guaranteed minimum high and low widths, so the downstream counter never misses or double-counts an edge.

## Interface
Parameters:
- `PULSE_CYCLES`, default 4: clock periods `des` is held high per point (≥1).
- `GAP_CYCLES`, default 4: clock periods `des` is held low between points (≥1).
- `PEND_W`, default 4: width of the pending-point counter; saturates at 2^PEND_W−1.

Ports:
- `clk`  in  1: system clock; all logic on its rising edge.
- `reset_n`  in  1: reset, asynchronous, active-low.
- `hit_valid`  in  1: one-cycle strobe; a scoring event occurs this cycle.
- `hit_points`  in  3: points for the event (0–7); ignored when `hit_valid`=0.
- `clear`  in  1: synchronous clear of pending points and overflow flag.
- `des`  out  1: registered score pulse; one rising edge = one point.
- `pending`  out  PEND_W: points accepted but not yet emitted.
- `busy`  out  1: high when the FSM is not IDLE or `pending`≠0.
- `overflow`  out  1: sticky; set when an add saturated `pending`.

## Operation
- Reset (async, `reset_n`=0): state IDLE, `des`=0, `pending`=0, `overflow`=0, phase counter=0, `busy`=0. Takes effect immediately, including mid-pulse.
- FSM states:
  - IDLE: `des`=0.
  - HIGH: `des`=1 for `PULSE_CYCLES` periods.
  - LOW: `des`=0 for `GAP_CYCLES` periods.
- FSM transitions:
  - IDLE → HIGH when registered `pending`≠0.
  - HIGH → LOW after `PULSE_CYCLES` periods.
  - LOW → HIGH after `GAP_CYCLES` periods if `pending`≠0, else LOW → IDLE.
- Decrement: every transition into HIGH decrements `pending` by 1 in the same edge.
- Pending update per edge: `pending_next = pending + (hit_valid ? hit_points : 0) − dec`.
  - Computed at PEND_W+1 bits.
  - If the result exceeds 2^PEND_W−1, `pending` = 2^PEND_W−1 and `overflow` is set.
  - A decrement never underflows, because it only occurs when `pending`≠0.
- `hit_valid` with `hit_points`=0 causes no change.
- Simultaneous hit and decrement apply in the same edge, e.g. pending 5, hit 2, decrement gives 6.
- `clear` has priority over hits and decrements:
  - `pending`←0 and `overflow`←0.
  - If in HIGH, go to LOW with the gap counter restarted, so a minimum low width is still honoured.
  - If in LOW or IDLE, state is unchanged.
- Phase counter: one counter sized for max(`PULSE_CYCLES`, `GAP_CYCLES`), reloaded on every state entry.

## Timing
- `des` comes straight from a flop; it never glitches.
- Latency: hit sampled at edge N → `pending` updated after edge N → `des` rises after edge N+1, if the FSM was IDLE.
- Pulse period: `PULSE_CYCLES`+`GAP_CYCLES` per point. With defaults, rising edges are spaced 8 clocks apart.
- Hits arriving while HIGH/LOW are queued and do not shorten or restart the current pulse.
- `busy` is combinational from state and `pending`.
- `pending` and `overflow` are registered.

## Test plan
- Single hit, defaults: `hit_points`=1 at edge 0.
  - `pending` is 1 after edge 0, and 0 after edge 1.
  - `des` is high for edges 1–4 and low from edge 5.
  - IDLE and `busy`=0 after edge 9.
- Multi-point: `hit_points`=3 at edge 0.
  - `des` rises at edges 1, 9 and 17.
  - `pending` goes 2, 1, 0.
  - `busy` falls after edge 25.
  - Exactly 3 rising edges in total.
- Saturation, `PEND_W`=4: hits of 7 at edges 0, 1 and 2.
  - `pending` goes 7, then 13, then 15 with `overflow`=1.
  - Total `des` rising edges = 16.
  - `overflow` stays high until `clear`.
- Hit during drain: `hit_points`=2 arrives while in LOW with `pending`=1.
  - `pending`=3 next edge.
  - Subsequent pulses keep exact 4/4 spacing.
  - No extra or missing edges.
- Clear mid-pulse: assert `clear` in the 2nd HIGH cycle with `pending`=5.
  - `des`=0 next edge, `pending`=0, `overflow`=0.
  - `des` stays low for ≥4 cycles, then IDLE.
- Async reset mid-pulse: drop `reset_n` between clock edges while `des`=1.
  - `des`, `pending`, `overflow` and `busy` go to 0 without waiting for a clock edge.
  - After release, no pulse until a new hit.
